// File: rtl/candy_regwr.sv
// Register-file writeback arbiter: clears every register after reset, then queues
// mem/ex writebacks in program order and drains one entry per cycle to the write port.
module candy_regwr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] qaddr,
    output logic              qhit,
    output logic              init_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M2   = CW'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [PW-1:0]     head_reg, tail_reg, tail_next, ex_idx;
    logic [CW-1:0]     count_reg, count_next, push_cnt;
    logic              we_reg, init_done_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic run, mem_push, ex_push, pop;
    logic [DEPTH-1:0] hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= INIT;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT:    if (cnt_reg == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign run = (state_reg == RUN);

    // Readiness is judged on the pre-edge occupancy; mem is the older instruction so it
    // claims the last free slot before ex does.
    assign mem_ready = run && (count_reg < DEPTH_C);
    assign ex_ready  = run && ((count_reg <= DEPTH_M2) || ((count_reg < DEPTH_C) && !mem_valid));

    // Writes to r0 are accepted on the handshake and then dropped.
    assign mem_push = mem_valid && mem_ready && (mem_addr != '0);
    assign ex_push  = ex_valid && ex_ready && (ex_addr != '0);
    assign pop      = run && (count_reg != '0);

    assign push_cnt   = CW'(mem_push) + CW'(ex_push);
    assign count_next = count_reg + push_cnt - CW'(pop);
    assign ex_idx     = mem_push ? tail_reg + PW'(1) : tail_reg;
    assign tail_next  = tail_reg + PW'(mem_push) + PW'(ex_push);

    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_mem[tail_reg] <= mem_addr;
            data_mem[tail_reg] <= mem_data;
        end
        if (ex_push) begin
            addr_mem[ex_idx] <= ex_addr;
            data_mem[ex_idx] <= ex_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            we_reg        <= 1'b0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
            init_done_reg <= 1'b0;
        end else if (state_reg == INIT) begin
            we_reg    <= 1'b1;
            waddr_reg <= cnt_reg;
            wdata_reg <= '0;
            cnt_reg   <= cnt_reg + ADDR_W'(1);
            if (cnt_reg == LAST_ADDR) init_done_reg <= 1'b1;
        end else begin
            count_reg <= count_next;
            tail_reg  <= tail_next;
            if (pop) begin
                we_reg    <= 1'b1;
                waddr_reg <= addr_mem[head_reg];
                wdata_reg <= data_mem[head_reg];
                head_reg  <= head_reg + PW'(1);
            end else begin
                we_reg <= 1'b0;
            end
        end
    end

    // An entry is live when its distance from head is below the occupancy count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [PW-1:0] offset;
        assign offset  = PW'(gi) - head_reg;
        assign hit[gi] = ({1'b0, offset} < count_reg) && (addr_mem[gi] == qaddr);
    end

    assign qhit      = (qaddr != '0) && (|hit);
    assign we        = we_reg;
    assign waddr     = waddr_reg;
    assign wdata     = wdata_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_candy_regwr.sv
// Directed bench for candy_regwr: clear sequence, vector table for queueing/hazards,
// and a mid-operation reset.
module tb_candy_regwr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, ex_valid;
    logic        mem_ready, ex_ready;
    logic [4:0]  mem_addr, ex_addr, qaddr, waddr;
    logic [31:0] mem_data, ex_data, wdata;
    logic        we, qhit, init_done;

    int checks = 0;
    int failures = 0;

    candy_regwr dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
        .we(we), .waddr(waddr), .wdata(wdata),
        .qaddr(qaddr), .qhit(qhit), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [4:0]  qa;
        logic        e_mr, e_er, e_qh, e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                                input logic [4:0] qa, input logic mr, input logic er,
                                input logic qh, input logic w, input logic [4:0] wa,
                                input logic [31:0] wd);
        vec_t v;
        v.mv = mv; v.ma = ma; v.md = md; v.ev = ev; v.ea = ea; v.ed = ed; v.qa = qa;
        v.e_mr = mr; v.e_er = er; v.e_qh = qh; v.e_we = w; v.e_wa = wa; v.e_wd = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                         input logic [4:0] qa);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        ex_valid = ev; ex_addr = ea; ex_data = ed; qaddr = qa;
    endtask

    task automatic run_clear(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            check({tag, "_we"}, 32'(we), 32'd1);
            check({tag, "_waddr"}, 32'(waddr), 32'(i));
            check({tag, "_wdata"}, wdata, 32'd0);
            if (i < 31) begin
                check({tag, "_init_done_low"}, 32'(init_done), 32'd0);
                check({tag, "_mem_ready_init"}, 32'(mem_ready), 32'd0);
                check({tag, "_ex_ready_init"}, 32'(ex_ready), 32'd0);
            end
            $display("%s cycle %0d: we=%0d waddr=%0d wdata=%h", tag, i, we, waddr, wdata);
        end
        check({tag, "_init_done"}, 32'(init_done), 32'd1);
        check({tag, "_mem_ready_run"}, 32'(mem_ready), 32'd1);
        check({tag, "_ex_ready_run"}, 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, "_we_idle"}, 32'(we), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0,       0, 0, 0,        0,  1, 1, 0, 0, 31, 0);
        vecs[1]  = mk(0, 0, 0,       1, 5, 'h1234,   5,  1, 1, 0, 0, 31, 0);
        vecs[2]  = mk(0, 0, 0,       0, 0, 0,        5,  1, 1, 1, 1, 5,  'h1234);
        vecs[3]  = mk(0, 0, 0,       0, 0, 0,        5,  1, 1, 0, 0, 5,  'h1234);
        vecs[4]  = mk(1, 3, 'hA,     1, 4, 'hB,      4,  1, 1, 0, 0, 5,  'h1234);
        vecs[5]  = mk(0, 0, 0,       0, 0, 0,        4,  1, 1, 1, 1, 3,  'hA);
        vecs[6]  = mk(0, 0, 0,       0, 0, 0,        3,  1, 1, 0, 1, 4,  'hB);
        vecs[7]  = mk(0, 0, 0,       0, 0, 0,        4,  1, 1, 0, 0, 4,  'hB);
        vecs[8]  = mk(0, 0, 0,       1, 0, 'hFF,     0,  1, 1, 0, 0, 4,  'hB);
        vecs[9]  = mk(0, 0, 0,       1, 7, 'h77,     0,  1, 1, 0, 0, 4,  'hB);
        vecs[10] = mk(0, 0, 0,       0, 0, 0,        7,  1, 1, 1, 1, 7,  'h77);
        vecs[11] = mk(0, 0, 0,       0, 0, 0,        7,  1, 1, 0, 0, 7,  'h77);
        vecs[12] = mk(1, 10, 'h110,  1, 11, 'h111,   10, 1, 1, 0, 0, 7,  'h77);
        vecs[13] = mk(1, 12, 'h112,  1, 13, 'h113,   11, 1, 1, 1, 1, 10, 'h110);
        vecs[14] = mk(1, 14, 'h114,  1, 15, 'h115,   13, 1, 0, 1, 1, 11, 'h111);
        vecs[15] = mk(0, 0, 0,       1, 15, 'h115,   15, 1, 1, 0, 1, 12, 'h112);
        vecs[16] = mk(1, 16, 'h116,  1, 17, 'h117,   14, 1, 0, 1, 1, 13, 'h113);
        vecs[17] = mk(0, 0, 0,       0, 0, 0,        16, 1, 1, 1, 1, 14, 'h114);
        vecs[18] = mk(0, 0, 0,       0, 0, 0,        14, 1, 1, 0, 1, 15, 'h115);
        vecs[19] = mk(0, 0, 0,       0, 0, 0,        17, 1, 1, 0, 1, 16, 'h116);
        vecs[20] = mk(0, 0, 0,       0, 0, 0,        16, 1, 1, 0, 0, 16, 'h116);
        vecs[21] = mk(1, 0, 'h55,    1, 9, 'h99,     0,  1, 1, 0, 0, 16, 'h116);
        vecs[22] = mk(0, 0, 0,       0, 0, 0,        9,  1, 1, 1, 1, 9,  'h99);
        vecs[23] = mk(0, 0, 0,       0, 0, 0,        9,  1, 1, 0, 0, 9,  'h99);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_ex_ready", 32'(ex_ready), 32'd0);
        check("rst_qhit", 32'(qhit), 32'd0);
        rst = 1'b1;
        run_clear("init");

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].qa);
            #1;
            check($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
            check($sformatf("vec%0d_ex_ready", i), 32'(ex_ready), 32'(vecs[i].e_er));
            check($sformatf("vec%0d_qhit", i), 32'(qhit), 32'(vecs[i].e_qh));
            @(posedge clk); #1;
            check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(vecs[i].e_wa));
            check($sformatf("vec%0d_wdata", i), wdata, vecs[i].e_wd);
            $display("vec %0d: we=%0d waddr=%0d wdata=%h qhit=%0d", i, we, waddr, wdata, qhit);
        end

        // Queue three entries, then reset while they are pending.
        drive(1, 20, 'h120, 1, 21, 'h121, 0);
        @(posedge clk); #1;
        drive(1, 22, 'h122, 1, 23, 'h123, 0);
        @(posedge clk); #1;
        check("pre_rst_we", 32'(we), 32'd1);
        check("pre_rst_waddr", 32'(waddr), 32'd20);
        drive(0, 0, 0, 0, 0, 0, 22);
        #1;
        check("pre_rst_qhit", 32'(qhit), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_waddr", 32'(waddr), 32'd0);
        check("mid_rst_wdata", wdata, 32'd0);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
        check("mid_rst_ex_ready", 32'(ex_ready), 32'd0);
        check("mid_rst_qhit", 32'(qhit), 32'd0);
        $display("mid-run reset: we=%0d waddr=%0d qhit=%0d", we, waddr, qhit);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        run_clear("reinit");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("stale_we", 32'(we), 32'd0);
            check("stale_qhit", 32'(qhit), 32'd0);
            $display("post-reinit idle %0d: we=%0d waddr=%0d", i, we, waddr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/candy_regwr.md
CANDY_REGWR -- requirements
Module: candy_regwr

Interface
REQ-001 Parameter DATA_W, default 32, register data width (`RegBus).
REQ-002 Parameter ADDR_W, default 5, register address width (`RegAddrBus); register count = 2**ADDR_W.
REQ-003 Parameter DEPTH, default 4, write-queue entries, power of two >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-006 mem_valid / mem_ready  input / output  1 / 1  memory-stage writeback handshake.
REQ-007 mem_addr / mem_data  input  ADDR_W / DATA_W  memory-stage destination register and value.
REQ-008 ex_valid / ex_ready  input / output  1 / 1  execute-stage writeback handshake.
REQ-009 ex_addr / ex_data  input  ADDR_W / DATA_W  execute-stage destination register and value.
REQ-010 we  output  1  register-file write enable, registered.
REQ-011 waddr / wdata  output  ADDR_W / DATA_W  register-file write address and data, registered.
REQ-012 qaddr  input  ADDR_W  hazard-query address from decode.
REQ-013 qhit  output  1  combinational: qaddr matches a queued, not-yet-written entry.
REQ-014 init_done  output  1  high once the register-clear sequence has finished.

Function
REQ-015 FSM states INIT and RUN; reset enters INIT with clear counter cnt = 0.
REQ-016 INIT: on each edge drive we=1, waddr=cnt, wdata=0, then cnt+1; after waddr = 2**ADDR_W-1 is issued, go to RUN.
REQ-017 INIT covers exactly 2**ADDR_W cycles (32 at default); init_done rises on the edge entering RUN.
REQ-018 mem_ready and ex_ready SHALL be 0 in INIT and during reset.
REQ-019 RUN: a handshake completes on a rising edge with valid && ready both high.
REQ-020 mem_ready = (free >= 1), where free = DEPTH - count; count is the value before the edge.
REQ-021 ex_ready = (free >= 2) || (free >= 1 && !mem_valid); mem has priority as the older instruction.
REQ-022 Both handshakes in one edge enqueue mem entry first, then ex entry (program order).
REQ-023 A handshake with addr = 0 completes but is discarded and never enqueued; r0 is never written in RUN.
REQ-024 Pop: in RUN, if count > 0 before the edge, head is popped and presented as we=1, waddr, wdata for the following cycle; otherwise we=0.
REQ-025 Latency: entry enqueued at edge N into an empty queue appears on we/waddr/wdata after edge N+1.
REQ-026 No bypass: an entry is never pushed and popped on the same edge.
REQ-027 Simultaneous push and pop update count by pushes minus 1; readiness uses the pre-edge count, so a full queue refuses input even while popping.
REQ-028 Pointers wrap modulo DEPTH; count ranges 0..DEPTH and never overflows or underflows.
REQ-029 qhit = 1 iff qaddr != 0 and any occupied entry holds addr == qaddr; the entry being driven on waddr is not included.
REQ-030 waddr/wdata hold their last value when we=0.

Reset
REQ-031 rst=0 asynchronously forces we=0, waddr=0, wdata=0, init_done=0, count=0, pointers=0, cnt=0, state=INIT.
REQ-032 Reset mid-operation discards all queued entries; the clear sequence restarts from address 0 after rst rises.
REQ-033 qhit SHALL be 0 while in reset, since the queue is empty.

Verification
REQ-034 Release reset -> 32 consecutive cycles of we=1, waddr 0..31, wdata=0; then init_done=1, we=0, both readies=1.
REQ-035 RUN, empty queue, single ex handshake addr=5 data=0x1234 at edge N -> we=1 waddr=5 wdata=0x1234 after edge N+1 only.
REQ-036 Both valid at one edge, mem addr=3 data=0xA, ex addr=4 data=0xB -> writes r3=0xA then r4=0xB on consecutive cycles.
REQ-037 Hold ex_valid with distinct addrs until full -> ex_ready=0 at count=4; with mem_valid=1 and free=1, mem accepted and ex refused; no entry lost or reordered.
REQ-038 ex handshake addr=0 data=0xFF -> handshake completes, we stays 0, qhit(0)=0; entry addr=7 queued -> qhit=1 for qaddr=7 until popped.
REQ-039 Assert rst=0 with 3 entries queued -> outputs 0 immediately; after release -> full clear sequence, stale entries never written.
